// File: rtl/tt_sweep_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tt_sweep_ctrl_pkg
//   Shared definitions for the truth-table sweep controller.
//   - sweep_state_e : controller state encodings
//   - SETTLE_W      : width of the settle (wait) counter, enough for 0..15
// ---------------------------------------------------------------------------
package tt_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_e;

    localparam int SETTLE_W = 4;

endpackage : tt_sweep_ctrl_pkg

// File: rtl/tt_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tt_sweep_ctrl
//   Equivalence-checking sequencer for two implementations of one N_IN-input
//   boolean function. It walks x through 0 .. 2^N_IN-1. Each vector is held
//   for SETTLE+1 cycles, then sampled for one cycle in which a and b are
//   compared. The block reports a pass flag, a mismatch count and the lowest
//   failing vector.
//
// Parameters
//   N_IN   : number of function inputs (1..8)
//   SETTLE : idle cycles after a vector is applied before its sample (0..15)
//
// Ports
//   clk        in   clock, rising edge
//   reset_n    in   synchronous active-low reset
//   start      in   begin a sweep (honoured in IDLE or DONE)
//   abort      in   return to IDLE, keep partial results
//   x          out  [N_IN]   vector driven into both implementations
//   a, b       in   outputs of implementation A and B
//   busy       out  sweep in progress
//   done       out  sweep finished, results valid
//   pass       out  1 if the finished sweep saw no mismatches
//   err_count  out  [N_IN+1] number of mismatching vectors
//   fail_valid out  at least one mismatch captured
//   first_fail out  [N_IN]   lowest mismatching vector
// ---------------------------------------------------------------------------
module tt_sweep_ctrl
    import tt_sweep_ctrl_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] x,
    input  logic            a,
    input  logic            b,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] first_fail
);

    // Last vector of the sweep, compared against a counter one bit wider than
    // x so the comparison never depends on x wrapping back to zero.
    localparam logic [N_IN:0]         LAST_VEC  = {1'b0, {N_IN{1'b1}}};
    localparam logic [SETTLE_W-1:0]   SETTLE_LD = SETTLE_W'(SETTLE);

    sweep_state_e          state_q, state_d;
    logic [N_IN:0]         vec_q, vec_d;
    logic [SETTLE_W-1:0]   wait_q, wait_d;
    logic [N_IN:0]         err_q, err_d;
    logic                  fv_q, fv_d;
    logic [N_IN-1:0]       ff_q, ff_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;

    logic                  mismatch;

    assign mismatch = a ^ b;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values computed in the previous cycle regardless
    // of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            wait_q  <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            ff_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            ff_q    <= ff_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    // NOTE: every signal driven here gets a hold-value default first; a path
    // that leaves one unassigned would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        wait_d  = wait_q;
        err_d   = err_q;
        fv_d    = fv_q;
        ff_d    = ff_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;

        if (abort) begin
            // Results are left untouched so a partial sweep can be inspected.
            // In IDLE these assignments match the values already held.
            state_d = IDLE;
            vec_d   = '0;
            wait_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = APPLY;
                        vec_d   = '0;
                        wait_d  = SETTLE_LD;
                        err_d   = '0;
                        fv_d    = 1'b0;
                        ff_d    = '0;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        pass_d  = 1'b0;
                    end
                end

                APPLY: begin
                    // Counter reaching zero ends APPLY, giving SETTLE+1 cycles.
                    if (wait_q == '0) begin
                        state_d = SAMPLE;
                    end else begin
                        wait_d = wait_q - 1'b1;
                    end
                end

                SAMPLE: begin
                    if (mismatch) begin
                        err_d = err_q + 1'b1;
                        if (!fv_q) begin
                            fv_d = 1'b1;
                            ff_d = vec_q[N_IN-1:0];
                        end
                    end
                    if (vec_q == LAST_VEC) begin
                        // x is held at the last vector while DONE.
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        state_d = APPLY;
                        vec_d   = vec_q + 1'b1;
                        wait_d  = SETTLE_LD;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign x          = vec_q[N_IN-1:0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign first_fail = ff_q;

endmodule : tt_sweep_ctrl

// File: tb/tb_tt_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tt_sweep_ctrl
//   Self-checking bench for tt_sweep_ctrl. dut1 (N_IN=2, SETTLE=1) checks a
//   function ~x[1]&x[0] against a copy with selectable faults; dut0
//   (N_IN=2, SETTLE=0) checks the shorter per-vector timing.
// ---------------------------------------------------------------------------
module tb_tt_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       abort;
    logic       start1, start0;

    logic [1:0] x1, x0;
    logic       a1, b1, a0, b0;
    logic       busy1, done1, pass1, fv1;
    logic       busy0, done0, pass0, fv0;
    logic [2:0] err1, err0;
    logic [1:0] ff1, ff0;

    // Fault mode for implementation B of dut1:
    //   0 equivalent, 1 flip at x=2, 2 flip everywhere, 3 flip at x=0
    int mode;

    always_comb begin
        a1 = ~x1[1] & x1[0];
        b1 = a1;
        case (mode)
            1:       b1 = a1 ^ (x1 == 2'd2);
            2:       b1 = ~a1;
            3:       b1 = a1 ^ (x1 == 2'd0);
            default: b1 = a1;
        endcase
    end

    assign a0 = ~x0[1] & x0[0];
    assign b0 = a0;

    tt_sweep_ctrl #(.N_IN(2), .SETTLE(1)) dut1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start1),
        .abort      (abort),
        .x          (x1),
        .a          (a1),
        .b          (b1),
        .busy       (busy1),
        .done       (done1),
        .pass       (pass1),
        .err_count  (err1),
        .fail_valid (fv1),
        .first_fail (ff1)
    );

    tt_sweep_ctrl #(.N_IN(2), .SETTLE(0)) dut0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start0),
        .abort      (abort),
        .x          (x0),
        .a          (a0),
        .b          (b0),
        .busy       (busy0),
        .done       (done0),
        .pass       (pass0),
        .err_count  (err0),
        .fail_valid (fv0),
        .first_fail (ff0)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset1(input string tag);
        check({tag, "_x"},     32'(x1),    32'd0);
        check({tag, "_busy"},  32'(busy1), 32'd0);
        check({tag, "_done"},  32'(done1), 32'd0);
        check({tag, "_pass"},  32'(pass1), 32'd0);
        check({tag, "_err"},   32'(err1),  32'd0);
        check({tag, "_fv"},    32'(fv1),   32'd0);
        check({tag, "_ff"},    32'(ff1),   32'd0);
    endtask

    // Pulse start on dut1 and count busy cycles; x must advance every 3 cycles.
    task automatic run_sweep1(output int cyc);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        cyc = 0;
        while (busy1 && cyc < 200) begin
            check("x_step", 32'(x1), 32'(cyc / 3));
            cyc++;
            tick();
        end
    endtask

    typedef struct {
        int   mode;
        logic exp_pass;
        int   exp_err;
        logic exp_fv;
        int   exp_ff;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;

        tbl[0] = '{mode: 0, exp_pass: 1'b1, exp_err: 0, exp_fv: 1'b0, exp_ff: 0};
        tbl[1] = '{mode: 1, exp_pass: 1'b0, exp_err: 1, exp_fv: 1'b1, exp_ff: 2};
        tbl[2] = '{mode: 2, exp_pass: 1'b0, exp_err: 4, exp_fv: 1'b1, exp_ff: 0};
        tbl[3] = '{mode: 3, exp_pass: 1'b0, exp_err: 1, exp_fv: 1'b1, exp_ff: 0};

        reset_n = 1'b0;
        abort   = 1'b0;
        start1  = 1'b0;
        start0  = 1'b0;
        mode    = 0;
        tick();
        tick();
        check_reset1("reset");
        reset_n = 1'b1;
        tick();

        // Full sweeps under each fault pattern.
        for (int i = 0; i < 4; i++) begin
            mode = tbl[i].mode;
            run_sweep1(cyc);
            check("busy_cycles", 32'(cyc),   32'd12);
            check("done",        32'(done1), 32'd1);
            check("busy_end",    32'(busy1), 32'd0);
            check("pass",        32'(pass1), 32'(tbl[i].exp_pass));
            check("err_count",   32'(err1),  32'(tbl[i].exp_err));
            check("fail_valid",  32'(fv1),   32'(tbl[i].exp_fv));
            check("first_fail",  32'(ff1),   32'(tbl[i].exp_ff));
            check("x_held",      32'(x1),    32'd3);
            tick();
            check("done_hold",   32'(done1), 32'd1);
        end

        // Abort during the SAMPLE cycle of x=1, after a mismatch at x=0.
        mode   = 3;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (5) tick();
        check("abort_pre_x", 32'(x1), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy1), 32'd0);
        check("abort_done", 32'(done1), 32'd0);
        check("abort_pass", 32'(pass1), 32'd0);
        check("abort_x",    32'(x1),    32'd0);
        check("abort_err",  32'(err1),  32'd1);
        check("abort_fv",   32'(fv1),   32'd1);
        check("abort_ff",   32'(ff1),   32'd0);
        tick();
        check("idle_stays", 32'(busy1), 32'd0);

        // Abort in IDLE leaves everything as it was.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_busy", 32'(busy1), 32'd0);
        check("idle_abort_x",    32'(x1),    32'd0);
        check("idle_abort_err",  32'(err1),  32'd1);
        check("idle_abort_fv",   32'(fv1),   32'd1);

        // start held high: one 12-cycle sweep, then a restart from DONE.
        mode   = 2;
        start1 = 1'b1;
        tick();
        cyc = 0;
        while (busy1 && cyc < 200) begin
            cyc++;
            tick();
        end
        check("held_busy_cycles", 32'(cyc),   32'd12);
        check("held_done",        32'(done1), 32'd1);
        check("held_err",         32'(err1),  32'd4);
        tick();
        check("restart_done", 32'(done1), 32'd0);
        check("restart_busy", 32'(busy1), 32'd1);
        check("restart_err",  32'(err1),  32'd0);
        check("restart_fv",   32'(fv1),   32'd0);
        check("restart_x",    32'(x1),    32'd0);
        start1 = 1'b0;
        abort  = 1'b1;
        tick();
        abort  = 1'b0;
        check("restart_abort_busy", 32'(busy1), 32'd0);

        // Reset mid-sweep at x=2, with errors already counted.
        mode   = 2;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (6) tick();
        check("rst_pre_x",   32'(x1),   32'd2);
        check("rst_pre_err", 32'(err1), 32'd2);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_reset1("midreset");
        mode = 0;
        run_sweep1(cyc);
        check("post_rst_cycles", 32'(cyc),   32'd12);
        check("post_rst_done",   32'(done1), 32'd1);
        check("post_rst_pass",   32'(pass1), 32'd1);
        check("post_rst_err",    32'(err1),  32'd0);

        // SETTLE=0: two cycles per vector, eight busy cycles.
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        cyc = 0;
        while (busy0 && cyc < 200) begin
            check("s0_x_step", 32'(x0), 32'(cyc / 2));
            cyc++;
            tick();
        end
        check("s0_busy_cycles", 32'(cyc),   32'd8);
        check("s0_done",        32'(done0), 32'd1);
        check("s0_pass",        32'(pass0), 32'd1);
        check("s0_err",         32'(err0),  32'd0);
        check("s0_fv",          32'(fv0),   32'd0);
        check("s0_ff",          32'(ff0),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_tt_sweep_ctrl
